// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small FIFO.
// tx_o and busy_o come straight from flops.
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 10416,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          nreset_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLK_PER_BIT);
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_q, bit_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            push, pop;
    logic            baud_end, have_data;

    assign ready_o   = (level_q < FULL);
    assign push      = valid_i && ready_o;
    assign baud_end  = (baud_q == BAUD_MAX);
    assign have_data = (level_q != '0);

    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign level_o = level_q;

    // Serialiser next state: a pop loads the shifter and starts a frame.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FIFO pointer and occupancy update; pointers wrap at FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage array; contents need no reset since level gates reads.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    // State registers; reset forces the line idle and empties the FIFO.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_PER_BIT=4, FIFO_DEPTH=8.
// A mid-bit sampling receiver collects bytes off tx_o.
module tb_uart_tx_fifo;

    logic       clk_i = 1'b0;
    logic       nreset_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [3:0] level_o;

    int vectors = 0;
    int miscompares = 0;

    logic       rx_en = 1'b0;
    logic [7:0] rx_byte;
    logic [7:0] rxq [$];
    int         ferr = 0;

    uart_tx_fifo #(
        .CLK_PER_BIT(4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i   (clk_i),
        .nreset_i(nreset_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .level_o (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Receiver: hunt a low line, then sample 1.5 cycles into each bit.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rx_en && tx_o == 1'b0) begin
                @(negedge clk_i);
                if (tx_o == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (4) @(negedge clk_i);
                        rx_byte[i] = tx_o;
                    end
                    repeat (4) @(negedge clk_i);
                    if (tx_o !== 1'b1) ferr++;
                    rxq.push_back(rx_byte);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_one(input logic [7:0] b);
        valid_i = 1'b1;
        data_i  = b;
        step();
        valid_i = 1'b0;
    endtask

    // Called #1 after the edge that drove the start bit low (k0 = 0).
    task automatic frame_check(input logic [7:0] b, input int k0);
        logic e;
        for (int k = k0; k < 40; k++) begin
            if (k / 4 == 0)      e = 1'b0;
            else if (k / 4 == 9) e = 1'b1;
            else                 e = b[k / 4 - 1];
            check($sformatf("frame_%02h_tx_k%0d", b, k), 32'(tx_o), 32'(e));
            check($sformatf("frame_%02h_busy_k%0d", b, k), 32'(busy_o), 32'd1);
            step();
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy_o || level_o != 4'd0) && n < limit) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n >= limit), 32'd0);
        repeat (4) step();
    endtask

    logic [7:0] vals [10];
    logic [7:0] sent [$];
    int acc;
    int guard;

    initial begin
        vals = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54,
                 8'h65, 8'h76, 8'h87, 8'h98, 8'hA9};
        nreset_i = 1'b0;
        valid_i  = 1'b0;
        data_i   = 8'h00;
        repeat (3) step();
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_level", 32'(level_o), 32'd0);
        nreset_i = 1'b1;
        repeat (2) step();
        rx_en = 1'b1;

        // Single 0xA5 frame and pop latency
        push_one(8'hA5);
        check("a5_level_push", 32'(level_o), 32'd1);
        check("a5_tx_idle", 32'(tx_o), 32'd1);
        check("a5_busy_idle", 32'(busy_o), 32'd0);
        step();
        check("a5_level_pop", 32'(level_o), 32'd0);
        frame_check(8'hA5, 0);
        check("a5_busy_end", 32'(busy_o), 32'd0);
        check("a5_tx_end", 32'(tx_o), 32'd1);
        repeat (3) step();

        // Three back-to-back bytes
        valid_i = 1'b1;
        data_i  = 8'h01;
        step();
        check("b2b_level0", 32'(level_o), 32'd1);
        data_i = 8'h02;
        step();
        check("b2b_level1", 32'(level_o), 32'd1);
        check("b2b_start", 32'(tx_o), 32'd0);
        data_i = 8'h03;
        step();
        check("b2b_level2", 32'(level_o), 32'd2);
        valid_i = 1'b0;
        frame_check(8'h01, 1);
        check("b2b_level3", 32'(level_o), 32'd1);
        frame_check(8'h02, 0);
        check("b2b_level4", 32'(level_o), 32'd0);
        frame_check(8'h03, 0);
        check("b2b_busy_end", 32'(busy_o), 32'd0);
        repeat (3) step();

        // Fill while busy; full FIFO with simultaneous pop refuses push
        rxq.delete();
        push_one(8'h11);
        step();
        valid_i = 1'b1;
        acc = 0;
        for (int c = 0; c < 39; c++) begin
            data_i = vals[acc];
            if (ready_o) begin
                step();
                acc++;
            end else begin
                step();
            end
        end
        check("fill_accepted", 32'(acc), 32'd8);
        check("fill_level", 32'(level_o), 32'd8);
        check("fill_ready", 32'(ready_o), 32'd0);
        step();
        check("full_pop_level", 32'(level_o), 32'd7);
        check("full_pop_ready", 32'(ready_o), 32'd1);
        valid_i = 1'b0;
        wait_idle(500);
        check("fill_rx_count", 32'(rxq.size()), 32'd9);
        if (rxq.size() == 9) begin
            check("fill_rx_0", 32'(rxq[0]), 32'h11);
            for (int i = 0; i < 8; i++)
                check($sformatf("fill_rx_%0d", i + 1),
                      32'(rxq[i + 1]), 32'(vals[i]));
        end

        // Reset mid-frame aborts and discards
        rx_en = 1'b0;
        push_one(8'hFF);
        valid_i = 1'b1;
        data_i  = 8'h77;
        step();
        valid_i = 1'b0;
        check("rstf_tx_start", 32'(tx_o), 32'd0);
        check("rstf_level", 32'(level_o), 32'd1);
        repeat (13) step();
        check("rstf_busy_pre", 32'(busy_o), 32'd1);
        #3 nreset_i = 1'b0;
        #1;
        check("rstf_tx", 32'(tx_o), 32'd1);
        check("rstf_busy", 32'(busy_o), 32'd0);
        check("rstf_level0", 32'(level_o), 32'd0);
        check("rstf_ready", 32'(ready_o), 32'd1);
        repeat (2) step();
        nreset_i = 1'b1;
        repeat (3) step();
        check("rstf_no_resume_tx", 32'(tx_o), 32'd1);
        check("rstf_no_resume_busy", 32'(busy_o), 32'd0);
        push_one(8'h3C);
        step();
        frame_check(8'h3C, 0);
        check("rstf_3c_end", 32'(busy_o), 32'd0);
        repeat (3) step();

        // 256 random bytes through the receiver model
        rxq.delete();
        ferr  = 0;
        rx_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            data_i  = 8'($urandom_range(0, 255));
            valid_i = 1'b1;
            guard   = 0;
            while (!ready_o && guard < 200) begin
                step();
                guard++;
            end
            if (guard >= 200) check("rand_push_timeout", 32'd1, 32'd0);
            sent.push_back(data_i);
            step();
            valid_i = 1'b0;
        end
        wait_idle(1000);
        check("rand_rx_count", 32'(rxq.size()), 32'd256);
        check("rand_framing", 32'(ferr), 32'd0);
        if (rxq.size() == 256) begin
            for (int i = 0; i < 256; i++)
                check($sformatf("rand_rx_%0d", i), 32'(rxq[i]), 32'(sent[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
